// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption, one round per clock; done pulses 10 edges after the start edge.
// start is ignored while busy; the key bus must stay stable until done.
module aes_inv_cipher_iter (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [127:0]    cypher_text,
    input  logic [1407:0]   expanded_key,
    output logic [127:0]    plain_text,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} fsm_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    fsm_t           r_fsm;
    logic [127:0]   r_state;
    logic [3:0]     r_rnd;
    logic [127:0]   r_plain;
    logic           r_busy;
    logic           r_done;

    logic [127:0]   w_rk;
    logic [127:0]   w_rk0;
    logic [127:0]   w_rk10;
    logic [127:0]   w_isr;
    logic [127:0]   w_isb;
    logic [127:0]   w_imc;
    logic [127:0]   w_final;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] d);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   x9 [4];
        logic [7:0]   xb [4];
        logic [7:0]   xd [4];
        logic [7:0]   xe [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = d[127-8*(r+4*c) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                x9[r] = x8 ^ a[r];
                xb[r] = x8 ^ x2 ^ a[r];
                xd[r] = x8 ^ x4 ^ a[r];
                xe[r] = x8 ^ x4 ^ x2;
            end
            o[127-32*c -: 8]  = xe[0] ^ xb[1] ^ xd[2] ^ x9[3];
            o[119-32*c -: 8]  = x9[0] ^ xe[1] ^ xb[2] ^ xd[3];
            o[111-32*c -: 8]  = xd[0] ^ x9[1] ^ xe[2] ^ xb[3];
            o[103-32*c -: 8]  = xb[0] ^ xd[1] ^ x9[2] ^ xe[3];
        end
        return o;
    endfunction

    assign w_rk0  = expanded_key[1407:1280];
    assign w_rk10 = expanded_key[127:0];

    // Middle rounds only ever need keys 1..9; the ends use fixed slices.
    always_comb begin
        w_rk = '0;
        for (int k = 1; k < 10; k++) begin
            if (r_rnd == 4'(k)) begin
                w_rk = expanded_key[1407-128*k -: 128];
            end
        end
    end

    always_comb begin
        w_isr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_isr[127-8*(r+4*c) -: 8] = r_state[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
    end

    always_comb begin
        w_isb = '0;
        for (int k = 0; k < 16; k++) begin
            w_isb[127-8*k -: 8] = INV_SBOX[w_isr[127-8*k -: 8]];
        end
    end

    assign w_imc   = inv_mix(w_isb ^ w_rk);
    assign w_final = w_isb ^ w_rk0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_rnd   <= '0;
            r_plain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_state <= cypher_text ^ w_rk10;
                        r_rnd   <= 4'd9;
                        r_busy  <= 1'b1;
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    r_rnd   <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) begin
                        r_fsm <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_plain <= w_final;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_fsm   <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign plain_text = r_plain;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors, back-to-back, mid-block reset, round trips.
module tb_aes_inv_cipher_iter;

    logic           clk;
    logic           rst;
    logic           start;
    logic [127:0]   cypher_text;
    logic [1407:0]  expanded_key;
    logic [127:0]   plain_text;
    logic           busy;
    logic           done;

    int n_cmp;
    int n_mis;
    int n_done;

    logic [7:0] sbox [256];

    aes_inv_cipher_iter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cypher_text  (cypher_text),
        .expanded_key (expanded_key),
        .plain_text   (plain_text),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box derived from the field inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] key_exp(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] e;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        e = '0;
        for (int i = 0; i < 44; i++) e[1407-32*i -: 32] = w[i];
        return e;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1407:0] ek);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] d;
        d = pt ^ ek[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox[d[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    t[4*c]   = gmul(s[4*c], 8'h02) ^ gmul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
                    t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 8'h02) ^ gmul(s[4*c+2], 8'h03) ^ s[4*c+3];
                    t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 8'h02) ^ gmul(s[4*c+3], 8'h03);
                    t[4*c+3] = gmul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 8'h02);
                end
                for (int k = 0; k < 16; k++) s[k] = t[k];
            end
            for (int k = 0; k < 16; k++) d[127-8*k -: 8] = s[k];
            d = d ^ ek[1407-128*r -: 128];
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_blk(input logic [127:0] ct, input logic [1407:0] ek);
        cypher_text  = ct;
        expanded_key = ek;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Entered at the negedge after the start edge; leaves at the negedge where done is seen.
    task automatic run_blk(input string tag, input logic [127:0] exp, input int poke_at);
        int           lat;
        int           bcnt;
        logic         stable;
        logic [127:0] prev;
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        prev   = plain_text;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (plain_text !== prev) stable = 1'b0;
            if (lat == poke_at) begin
                start       = 1'b1;
                cypher_text = ~cypher_text;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd10);
        chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd10);
        chk({tag, "_plain"}, plain_text, exp);
        chk({tag, "_busy_at_done"}, 128'(busy), 128'd0);
        chk({tag, "_plain_stable"}, 128'(stable), 128'd1);
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [1407:0] ek_b;
        logic [1407:0] ek_c;
        logic [1407:0] ek_r;
        logic [127:0]  key_r;
        logic [127:0]  pt_r;
        int            done_seen;

        n_cmp = 0;
        n_mis = 0;
        n_done = 0;
        rst = 1'b0;
        start = 1'b0;
        cypher_text = '0;
        expanded_key = '0;
        build_sbox();
        ek_b = key_exp(KEY_B);
        ek_c = key_exp(KEY_C);

        #2 rst = 1'b1;
        #3;
        chk("reset_plain", plain_text, 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        start_blk(CT_B, ek_b);
        run_blk("appB", PT_B, -1);
        @(negedge clk);
        chk("appB_done_drop", 128'(done), 128'd0);
        chk("appB_plain_held", plain_text, PT_B);
        @(negedge clk);

        start_blk(CT_C, ek_c);
        run_blk("appC", PT_C, -1);
        @(negedge clk);

        start_blk(CT_B, ek_b);
        run_blk("b2b_first", PT_B, 5);
        start_blk(CT_C, ek_c);
        run_blk("b2b_second", PT_C, -1);
        @(negedge clk);

        start_blk(CT_B, ek_b);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_plain", plain_text, 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("midrst_no_done", 128'(done_seen), 128'd0);
        rst = 1'b0;
        start_blk(CT_C, ek_c);
        run_blk("after_rst", PT_C, -1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            key_r = {$urandom, $urandom, $urandom, $urandom};
            pt_r  = {$urandom, $urandom, $urandom, $urandom};
            ek_r  = key_exp(key_r);
            start_blk(aes_enc(pt_r, ek_r), ek_r);
            run_blk($sformatf("rt%0d", i), pt_r, -1);
            @(negedge clk);
        end

        chk("done_count", 128'(n_done), 128'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
